// File: rtl/caster_pkg.sv
// Shared constants for the VRAM-to-EPD pixel path: pixel/word/beat widths and
// the pix_unpack state encodings.
package caster_pkg;

    localparam int PIX_W  = 16;
    localparam int WORD_W = 8 * PIX_W;
    localparam int BEAT_W = 4 * PIX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO with a combinational head output and a synchronous
// clear; DEPTH must be a power of 2 so the pointers wrap naturally.
module pix_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the top level gates everything it shows.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pix_unpack.sv
// Splits 128-bit VRAM words into 64-bit framed beats for the EPD pipeline.
// Handshakes: a word is taken whenever pix_read_valid is high (no backpressure; ready is advisory, one cycle ahead); a beat moves when out_valid && out_ready.
module pix_unpack
    import caster_pkg::*;
#(
    parameter int H_PIX      = 1600,
    parameter int V_LINES    = 1200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        vsync,
    input  logic [WORD_W-1:0]           pix_read,
    input  logic                        pix_read_valid,
    output logic                        pix_read_ready,
    output logic [BEAT_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic                        out_eof,
    output logic                        frame_done,
    output logic                        error,
    output logic [1:0]                  dbg_state,
    output logic [$clog2(FIFO_DEPTH):0] dbg_count
);
    localparam int X_W   = $clog2(H_PIX / 4);
    localparam int Y_W   = $clog2(V_LINES);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WI_W  = $clog2(H_PIX * V_LINES / 8) + 1;

    localparam logic [X_W-1:0]   X_LAST = X_W'(H_PIX / 4 - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(V_LINES - 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HI_WM  = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [WI_W-1:0]  TOTAL  = WI_W'(H_PIX * V_LINES / 8);

    logic [1:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              done_q, done_d;
    logic              hs_q, hs_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [WI_W-1:0]   wi_q, wi_d;

    logic              active, flush, xfer, at_eol, at_eof;
    logic              push, pop, stray, fifo_clr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [WORD_W-1:0] head;

    pix_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (push),
        .pop   (pop),
        .din   (pix_read),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        active    = (state_q == ST_ACTIVE);
        flush     = !enable || vsync;
        out_valid = active && (count != '0);
        xfer      = out_valid && out_ready && !flush;
        at_eol    = (x_q == X_LAST);
        at_eof    = at_eol && (y_q == Y_LAST);
        push      = pix_read_valid && active && (count < FULL) && !flush;
        pop       = xfer && hs_q;
        stray     = pix_read_valid && (!active || (count == FULL));

        state_d = state_q;
        hs_d    = hs_q;
        x_d     = x_q;
        y_d     = y_q;
        wi_d    = wi_q;
        done_d  = 1'b0;
        error_d = error_q || stray;

        if (!enable) begin
            state_d = ST_IDLE;
            hs_d    = 1'b0;
            x_d     = '0;
            y_d     = '0;
            wi_d    = '0;
        end else if (vsync) begin
            // A vsync inside an active frame means the previous frame came up short.
            if (active) error_d = 1'b1;
            state_d = ST_ACTIVE;
            hs_d    = 1'b0;
            x_d     = '0;
            y_d     = '0;
            wi_d    = '0;
        end else begin
            if (push) wi_d = wi_q + WI_W'(1);
            if (xfer) begin
                hs_d = !hs_q;
                if (at_eol) begin
                    x_d = '0;
                    y_d = at_eof ? '0 : y_q + Y_W'(1);
                end else begin
                    x_d = x_q + X_W'(1);
                end
                if (at_eof) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        fifo_clr = flush || done_d;
        if (fifo_clr)          count_nxt = '0;
        else if (push && !pop) count_nxt = count + CNT_W'(1);
        else if (pop && !push) count_nxt = count - CNT_W'(1);
        else                   count_nxt = count;

        // Two free slots absorb a strobe issued on the cycle ready falls.
        ready_d = (state_d == ST_ACTIVE) && (count_nxt <= HI_WM) && (wi_d < TOTAL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            hs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            wi_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            error_q <= error_d;
            done_q  <= done_d;
            hs_q    <= hs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wi_q    <= wi_d;
        end
    end

    assign out_data       = out_valid ? (hs_q ? head[WORD_W-1:BEAT_W] : head[BEAT_W-1:0]) : '0;
    assign out_sof        = out_valid && (x_q == '0) && (y_q == '0);
    assign out_eol        = out_valid && at_eol;
    assign out_eof        = out_valid && at_eof;
    assign pix_read_ready = ready_q;
    assign frame_done     = done_q;
    assign error          = error_q;
    assign dbg_state      = state_q;
    assign dbg_count      = count;

endmodule
